// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU tile buffering datapath.
package tpu_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_SIZE   = 2;

  // Tile at the default geometry. Parametrised modules declare their own
  // tile type with the same shape, tile[row][col][bit], because a package
  // typedef cannot take module parameters.
  typedef logic [DEF_SIZE-1:0][DEF_SIZE-1:0][DEF_DATA_W-1:0] tile_t;

  // Ring-buffer pointer increment for any depth, including non powers of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/tile_transpose.sv
// Purely combinational tile transpose: o_tile[r][c] = i_tile[c][r].
module tile_transpose
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SIZE   = DEF_SIZE
) (
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] i_tile,
  output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] o_tile
);

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      assign o_tile[r][c] = i_tile[c][r];
    end
  end

endmodule

// File: rtl/tile_fifo_xpose.sv
// Tile FIFO between the tile loader and the systolic array, with optional
// transpose on pop, flush, almost-full/empty levels and sticky error flags.
module tile_fifo_xpose
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned SIZE     = DEF_SIZE,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  push,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] din,
  output logic                                  push_rdy,
  input  logic                                  pop,
  input  logic                                  pop_t,
  output logic                                  pop_rdy,
  output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0]            count,
  output logic                                  almost_full,
  output logic                                  almost_empty,
  output logic                                  err_ovf,
  output logic                                  err_udf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_t;

  tile_t             r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  tile_t             r_dout;
  logic              r_err_ovf;
  logic              r_err_udf;

  logic              w_push_rdy;
  logic              w_pop_rdy;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [PTR_W-1:0]  w_wptr_nxt;
  logic [PTR_W-1:0]  w_rptr_nxt;
  tile_t             w_head;
  tile_t             w_head_t;
  tile_t             w_dout_nxt;

  // Readiness comes from the count register only; no look-ahead on pop.
  assign w_push_rdy = (r_count < FULL_CNT);
  assign w_pop_rdy  = (r_count != '0);

  // Flush and reset suppress transfers, so they also suppress the error flags.
  assign w_push_ok  = push && w_push_rdy && !flush;
  assign w_pop_ok   = pop  && w_pop_rdy  && !flush;

  assign w_wptr_nxt = PTR_W'(ptr_inc(32'(r_wptr), DEPTH));
  assign w_rptr_nxt = PTR_W'(ptr_inc(32'(r_rptr), DEPTH));

  assign w_head = r_mem[r_rptr];

  tile_transpose #(
    .DATA_W (DATA_W),
    .SIZE   (SIZE)
  ) u_transpose (
    .i_tile (w_head),
    .o_tile (w_head_t)
  );

  assign w_dout_nxt = pop_t ? w_head_t : w_head;

  // NOTE: storage has no reset; the count and pointers alone decide which
  // slots hold valid tiles, and leaving the array unreset keeps it in RAM.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wptr] <= din;
    end
  end

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what lets a simultaneous pop read the old head without bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_dout    <= '0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push && !w_push_rdy) r_err_ovf <= 1'b1;
      if (pop  && !w_pop_rdy)  r_err_udf <= 1'b1;

      if (w_push_ok) r_wptr <= w_wptr_nxt;

      if (w_pop_ok) begin
        r_dout <= w_dout_nxt;
        r_rptr <= w_rptr_nxt;
      end

      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign push_rdy     = w_push_rdy;
  assign pop_rdy      = w_pop_rdy;
  assign dout         = r_dout;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign err_ovf      = r_err_ovf;
  assign err_udf      = r_err_udf;

endmodule

// File: tb/tb_tile_fifo_xpose.sv
// Directed bench for tile_fifo_xpose at default geometry plus a queue-model
// run on a 16-bit, 4x4, depth-5 instance.
module tb_tile_fifo_xpose;

  typedef logic [1:0][1:0][7:0]   tile8_t;
  typedef logic [3:0][3:0][15:0]  tile16_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DATA_W=8, SIZE=2, DEPTH=3
  logic       rst, flush, push, pop, pop_t;
  tile8_t     din, dout;
  logic       push_rdy, pop_rdy, almost_full, almost_empty, err_ovf, err_udf;
  logic [1:0] count;

  tile_fifo_xpose u_dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .din(din),
    .push_rdy(push_rdy), .pop(pop), .pop_t(pop_t), .pop_rdy(pop_rdy),
    .dout(dout), .count(count), .almost_full(almost_full),
    .almost_empty(almost_empty), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  // Wide instance: DATA_W=16, SIZE=4, DEPTH=5
  logic       b_rst, b_flush, b_push, b_pop, b_pop_t;
  tile16_t    b_din, b_dout;
  logic       b_push_rdy, b_pop_rdy, b_almost_full, b_almost_empty, b_err_ovf, b_err_udf;
  logic [2:0] b_count;

  tile_fifo_xpose #(.DATA_W(16), .SIZE(4), .DEPTH(5)) u_dut_big (
    .clk(clk), .rst(b_rst), .flush(b_flush), .push(b_push), .din(b_din),
    .push_rdy(b_push_rdy), .pop(b_pop), .pop_t(b_pop_t), .pop_rdy(b_pop_rdy),
    .dout(b_dout), .count(b_count), .almost_full(b_almost_full),
    .almost_empty(b_almost_empty), .err_ovf(b_err_ovf), .err_udf(b_err_udf)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tile8_t mk8(input int a00, input int a01, input int a10, input int a11);
    tile8_t t;
    t[0][0] = 8'(a00); t[0][1] = 8'(a01);
    t[1][0] = 8'(a10); t[1][1] = 8'(a11);
    return t;
  endfunction

  function automatic tile16_t xp16(input tile16_t x);
    tile16_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = x[c][r];
    return t;
  endfunction

  function automatic tile16_t rnd16();
    tile16_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = 16'($urandom_range(0, 65535));
    return t;
  endfunction

  tile8_t  ta, tb, tc, td, te, tf, tg, th, tx;
  tile16_t q[$];
  tile16_t bexp_dout;
  logic    ok_push, ok_pop;

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; pop_t = 1'b0; din = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_pop_t = 1'b0; b_din = '0;
    ta = mk8(1, 2, 3, 4);     tb = mk8(5, 6, 7, 8);
    tc = mk8(9, 10, 13, 14);  td = mk8(15, 16, 17, 18);
    te = mk8(31, 32, 33, 34); tf = mk8(41, 42, 43, 44);
    tg = mk8(51, 52, 53, 54); th = mk8(61, 62, 63, 64);
    tx = mk8(71, 72, 73, 74);

    // 1: reset
    tick(); tick();
    rst = 1'b0; b_rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_push_rdy", push_rdy, 1);
    chk("rst_pop_rdy", pop_rdy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_udf", err_udf, 0);

    // 2: single push then straight pop
    push = 1'b1; din = mk8(11, 12, 21, 22);
    tick(); push = 1'b0;
    chk("t2_count1", count, 1);
    pop = 1'b1; pop_t = 1'b0;
    tick(); pop = 1'b0;
    chk("t2_count0", count, 0);
    chk("t2_dout", dout, mk8(11, 12, 21, 22));

    // 3: fill to full
    push = 1'b1;
    din = ta; tick();
    din = tb; tick();
    din = tc; tick();
    push = 1'b0;
    chk("t3_count", count, 3);
    chk("t3_push_rdy", push_rdy, 0);
    chk("t3_almost_full", almost_full, 1);
    chk("t3_almost_empty", almost_empty, 0);

    // 4: push+pop while full -> push rejected, transposed pop of A
    push = 1'b1; din = td; pop = 1'b1; pop_t = 1'b1;
    tick();
    chk("t4_err_ovf", err_ovf, 1);
    chk("t4_count", count, 2);
    chk("t4_dout_xpose_a", dout, mk8(1, 3, 2, 4));
    // push+pop at count 2: D lands in slot 0 after the wrap, B comes out
    pop_t = 1'b0;
    tick();
    push = 1'b0;
    chk("t4_count_hold", count, 2);
    chk("t4_dout_b", dout, tb);
    tick();
    chk("t4_dout_c", dout, tc);
    tick(); pop = 1'b0;
    chk("t4_dout_d", dout, td);
    chk("t4_count_empty", count, 0);
    chk("t4_err_udf", err_udf, 0);

    // reset while a tile is queued
    push = 1'b1; din = tx; tick(); push = 1'b0;
    chk("mid_count_pre", count, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_err_ovf", err_ovf, 0);

    // 5: flush with push/pop asserted, then pop while empty
    push = 1'b1;
    din = te; tick();
    din = tf; tick();
    push = 1'b0; pop = 1'b1; tick(); pop = 1'b0;
    chk("t5_dout_e", dout, te);
    push = 1'b1; din = th; tick();
    chk("t5_count2", count, 2);
    flush = 1'b1; din = tg; pop = 1'b1;
    tick();
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    chk("t5_flush_count", count, 0);
    chk("t5_flush_dout_hold", dout, te);
    chk("t5_flush_err_ovf", err_ovf, 0);
    chk("t5_flush_err_udf", err_udf, 0);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("t5_udf", err_udf, 1);
    chk("t5_udf_dout_hold", dout, te);
    chk("t5_udf_count", count, 0);
    push = 1'b1; din = tg; tick(); push = 1'b0;
    pop = 1'b1; tick(); pop = 1'b0;
    chk("t5_after_flush_dout", dout, tg);

    // 6: wide instance against a queue model
    bexp_dout = '0;
    for (int i = 0; i < 12; i++) begin
      b_push  = ($urandom_range(0, 3) != 0);
      b_pop   = ($urandom_range(0, 2) != 0);
      b_pop_t = 1'($urandom_range(0, 1));
      b_din   = rnd16();
      ok_push = b_push && (q.size() < 5);
      ok_pop  = b_pop && (q.size() > 0);
      tick();
      if (ok_pop) begin
        bexp_dout = b_pop_t ? xp16(q[0]) : q[0];
        void'(q.pop_front());
      end
      if (ok_push) q.push_back(b_din);
      chk("t6_dout", b_dout, bexp_dout);
      chk("t6_count", b_count, q.size());
    end
    b_pop = 1'b0; b_push = 1'b1; b_din = rnd16();
    tick(); b_push = 1'b0;
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    chk("t6_rst_count", b_count, 0);
    chk("t6_rst_dout", b_dout, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
